// File: rtl/alu_pkg.sv
// Shared opcode and sequencer state encodings for the ALU and its accumulator controller.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_LOAD = 3'b000,
        OP_ADD  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_SUB  = 3'b100,
        OP_CLR  = 3'b101,
        OP_EMIT = 3'b110,
        OP_NOP  = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        EMIT = 2'd2
    } acc_state_t;

endpackage

// File: rtl/alu.sv
// Combinational w-bit ALU: ADD, AND, OR, SUB modulo 2^w; other codes yield zero.
module alu
    import alu_pkg::*;
#(
    parameter int w = 8
) (
    input  logic [w-1:0] i_a,
    input  logic [w-1:0] i_b,
    input  alu_op_t      i_op,
    output logic [w-1:0] o_res
);

    always_comb begin
        o_res = '0;
        case (i_op)
            OP_ADD:  o_res = i_a + i_b;
            OP_AND:  o_res = i_a & i_b;
            OP_OR:   o_res = i_a | i_b;
            OP_SUB:  o_res = i_a - i_b;
            default: o_res = '0;
        endcase
    end

endmodule

// File: rtl/alu_acc_ctrl.sv
// Accumulator sequencer: accepts one command per two cycles, runs it through the ALU
// and emits the accumulator downstream on request.
module alu_acc_ctrl
    import alu_pkg::*;
#(
    parameter int w = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_op,
    input  logic [w-1:0] cmd_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [w-1:0] out_data,
    output logic         out_zero,
    output logic [w-1:0] acc,
    output logic [7:0]   count
);

    acc_state_t   r_state;
    alu_op_t      op_q;
    logic [w-1:0] opd_q;
    logic [w-1:0] r_acc;
    logic [w-1:0] r_out_data;
    logic [7:0]   r_count;
    logic [w-1:0] w_alu_res;
    logic [w-1:0] w_acc_nxt;

    alu #(.w(w)) u_alu (
        .i_a   (r_acc),
        .i_b   (opd_q),
        .i_op  (op_q),
        .o_res (w_alu_res)
    );

    // Opcodes the ALU does not implement are resolved here.
    always_comb begin
        w_acc_nxt = r_acc;
        case (op_q)
            OP_LOAD:                     w_acc_nxt = opd_q;
            OP_ADD, OP_AND, OP_OR, OP_SUB: w_acc_nxt = w_alu_res;
            OP_CLR:                      w_acc_nxt = '0;
            default:                     w_acc_nxt = r_acc;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            op_q       <= OP_LOAD;
            opd_q      <= '0;
            r_acc      <= '0;
            r_out_data <= '0;
            r_count    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q    <= alu_op_t'(cmd_op);
                        opd_q   <= cmd_data;
                        r_count <= r_count + 8'd1;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_acc <= w_acc_nxt;
                    if (op_q == OP_EMIT) begin
                        r_out_data <= r_acc;
                        r_state    <= EMIT;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                EMIT: begin
                    if (out_ready) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Handshake outputs decode state only; reset forces cmd_ready low while asserted.
    assign cmd_ready = (r_state == IDLE) && !reset;
    assign out_valid = (r_state == EMIT);
    assign out_data  = r_out_data;
    assign out_zero  = (r_out_data == '0);
    assign acc       = r_acc;
    assign count     = r_count;

endmodule

// File: tb/tb_alu_acc_ctrl.sv
// Randomized and directed bench for alu_acc_ctrl against a command-level reference model.
module tb_alu_acc_ctrl;

    logic       clk = 0;
    logic       reset = 1;
    logic       cmd_valid = 0;
    logic       cmd_ready;
    logic [2:0] cmd_op = 0;
    logic [7:0] cmd_data = 0;
    logic       out_valid;
    logic       out_ready = 0;
    logic [7:0] out_data;
    logic       out_zero;
    logic [7:0] acc;
    logic [7:0] count;

    int n_chk  = 0;
    int n_pass = 0;
    int m_acc  = 0;
    int m_cnt  = 0;

    alu_acc_ctrl #(.w(8)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_zero(out_zero),
        .acc(acc), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Reference: acc after one command, plain modulo-256 arithmetic.
    function automatic int ref_acc(input int a, input int op, input int d);
        case (op)
            0: return d;
            1: return (a + d) % 256;
            2: return a & d;
            3: return a | d;
            4: return (a - d + 256) % 256;
            5: return 0;
            default: return a;
        endcase
    endfunction

    // Called at a negedge with the DUT idle. bp = back-pressure cycles for EMIT.
    task automatic do_cmd(input int op, input int d, input int bp);
        int snap;
        chk("ready_idle", cmd_ready, 1);
        cmd_valid = 1; cmd_op = op[2:0]; cmd_data = d[7:0];
        @(negedge clk);
        m_cnt = (m_cnt + 1) % 256;
        chk("ready_exec", cmd_ready, 0);
        chk("count_acc", count, m_cnt);
        // Keep valid high with junk: must not be taken while busy.
        cmd_op = $urandom_range(0, 7); cmd_data = $urandom_range(0, 255);
        @(negedge clk);
        snap = m_acc;
        m_acc = ref_acc(m_acc, op, d);
        chk("acc", acc, m_acc);
        if (op == 6) begin
            chk("out_valid", out_valid, 1);
            chk("ready_emit", cmd_ready, 0);
            chk("out_data", out_data, snap);
            chk("out_zero", out_zero, snap == 0);
            for (int i = 0; i < bp; i++) begin
                @(negedge clk);
                chk("bp_valid", out_valid, 1);
                chk("bp_data", out_data, snap);
                chk("bp_ready", cmd_ready, 0);
                chk("bp_count", count, m_cnt);
            end
            out_ready = 1;
            @(negedge clk);
            out_ready = 0;
            chk("xfer_done", out_valid, 0);
            chk("count_emit", count, m_cnt);
        end
        chk("ready_back", cmd_ready, 1);
        cmd_valid = 0;
    endtask

    task automatic reset_check(input string tag);
        #2 reset = 1;
        #1;
        chk({tag, "_acc"}, acc, 0);
        chk({tag, "_cnt"}, count, 0);
        chk({tag, "_ov"}, out_valid, 0);
        chk({tag, "_rdy"}, cmd_ready, 0);
        chk({tag, "_oz"}, out_zero, 1);
        cmd_valid = 0; out_ready = 0;
        @(negedge clk);
        reset = 0;
        m_acc = 0; m_cnt = 0;
        @(negedge clk);
    endtask

    initial begin
        #3;
        chk("rst_acc", acc, 0);
        chk("rst_cnt", count, 0);
        chk("rst_rdy", cmd_ready, 0);
        chk("rst_ov", out_valid, 0);
        chk("rst_od", out_data, 0);
        chk("rst_oz", out_zero, 1);
        @(negedge clk); @(negedge clk);
        reset = 0;
        @(negedge clk);
        chk("rel_rdy", cmd_ready, 1);

        // 1: load/add/emit
        do_cmd(0, 8'h05, 0); do_cmd(1, 8'h03, 0); do_cmd(6, 0, 0);
        chk("t1_od", out_data, 8'h08);
        chk("t1_cnt", count, 3);
        // 2: wrap-around arithmetic
        do_cmd(0, 8'hF0, 0); do_cmd(1, 8'h20, 0);
        chk("t2_wrap", acc, 8'h10);
        do_cmd(4, 8'h10, 0); do_cmd(6, 0, 0);
        chk("t2_oz", out_zero, 1);
        do_cmd(4, 8'h01, 0);
        chk("t2_borrow", acc, 8'hFF);
        // 3: logic ops, clr, nop
        reset_check("r0");
        do_cmd(0, 8'hCC, 0); do_cmd(2, 8'hAA, 0);
        chk("t3_and", acc, 8'h88);
        do_cmd(3, 8'h03, 0);
        chk("t3_or", acc, 8'h8B);
        do_cmd(5, 8'h77, 0); do_cmd(7, 8'h55, 0);
        chk("t3_nop", acc, 0);
        chk("t3_cnt", count, 5);
        // 4: back-pressure
        do_cmd(0, 8'h3C, 0); do_cmd(6, 0, 5);
        chk("t4_od", out_data, 8'h3C);

        // 5a: reset during EXEC of ADD
        do_cmd(0, 8'h11, 0);
        cmd_valid = 1; cmd_op = 3'd1; cmd_data = 8'h22;
        @(negedge clk);
        chk("t5_exec_rdy", cmd_ready, 0);
        reset_check("r_exec");
        do_cmd(0, 8'h42, 0);
        chk("t5_after", acc, 8'h42);
        // 5b: reset during EMIT back-pressure
        do_cmd(6, 0, 2);
        cmd_valid = 1; cmd_op = 3'd6;
        @(negedge clk); @(negedge clk);
        chk("t5_emit_ov", out_valid, 1);
        reset_check("r_emit");
        do_cmd(1, 8'h07, 0);
        chk("t5_after2", acc, 8'h07);

        // 6: 257 NOPs wrap count
        reset_check("r6");
        do_cmd(0, 8'h9A, 0);
        for (int i = 0; i < 257; i++) do_cmd(7, $urandom_range(0, 255), 0);
        chk("t6_cnt", count, 2);
        chk("t6_acc", acc, 8'h9A);
        reset_check("r7");
        for (int i = 0; i < 257; i++) do_cmd(7, 0, 0);
        chk("t6_cnt1", count, 1);

        // Random commands
        for (int i = 0; i < 150; i++)
            do_cmd($urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 3));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
